// File: rtl/raw_scoreboard.sv
// -----------------------------------------------------------------------------
// raw_scoreboard
//
// Read-after-write hazard tracker for a 5-stage pipeline. It keeps a
// destination tag for each instruction in execute, memory and writeback. For
// the instruction in decode it produces a load-use stall request and a forward
// select for each source operand.
//
// Parameters:
//   W_BYPASS  1 = forward from writeback (11); 0 = register file is
//             write-through, so a writeback match selects the register file (00)
//   CNT_W     width of the optional stall counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   inst_d     instruction currently in decode
//   flush      taken redirect; the decode instruction is killed this cycle
//   stall      hold PC/decode and inject a bubble into execute
//   fwd_rs1    rs1 source: 00 regfile, 01 execute, 10 memory, 11 writeback
//   fwd_rs2    rs2 source, same encoding
//   stall_cnt  saturating count of stall cycles (only when the macro
//              RAW_SCOREBOARD_STALL_CNT_EN is defined)
// -----------------------------------------------------------------------------
module raw_scoreboard #(
  parameter bit W_BYPASS = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_d,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_rs1,
  output logic [1:0]  fwd_rs2
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BCC   = 7'b1100011;
  localparam logic [6:0] OP_LCC   = 7'b0000011;
  localparam logic [6:0] OP_SCC   = 7'b0100011;
  localparam logic [6:0] OP_MCC   = 7'b0010011;
  localparam logic [6:0] OP_RCC   = 7'b0110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } tag_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = inst_d[6:0];
  assign rd     = inst_d[11:7];
  assign rs1    = inst_d[19:15];
  assign rs2    = inst_d[24:20];

  // funct3/funct7 do not affect hazard tracking
  logic unused_funct;
  assign unused_funct = ^{inst_d[31:25], inst_d[14:12]};

  // Decode
  logic use_rs1;
  logic use_rs2;
  logic wr_rd;
  logic is_load;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_load = 1'b0;
    unique case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: wr_rd = 1'b1;
      OP_JALR, OP_MCC: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
      end
      OP_LCC: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        is_load = 1'b1;
      end
      OP_BCC, OP_SCC: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_RCC: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
      end
      default: ;
    endcase
    // Writes to x0 are architecturally discarded, so they never create a hazard
    if (rd == 5'd0) wr_rd = 1'b0;
  end

  // Tag pipeline
  tag_t tag_x_q, tag_x_d;
  tag_t tag_m_q, tag_m_d;
  tag_t tag_w_q, tag_w_d;

  function automatic logic tag_match(input tag_t t, input logic [4:0] a, input logic use_f);
    return t.valid && use_f && (a != 5'd0) && (t.rd == a);
  endfunction

  logic x1, m1, w1, x2, m2, w2;
  logic load_hit;

  always_comb begin
    x1 = tag_match(tag_x_q, rs1, use_rs1);
    m1 = tag_match(tag_m_q, rs1, use_rs1);
    w1 = tag_match(tag_w_q, rs1, use_rs1);
    x2 = tag_match(tag_x_q, rs2, use_rs2);
    m2 = tag_match(tag_m_q, rs2, use_rs2);
    w2 = tag_match(tag_w_q, rs2, use_rs2);
    load_hit = tag_x_q.is_load && (x1 || x2);
  end

  // Priority X > M > W. A load in X has no data yet, so it falls through to
  // older stages; the stall holds decode until the load reaches M. An older
  // match behind an X load is never consumed because that cycle is stalled.
  function automatic logic [1:0] fwd_sel(input logic mx, input logic mm, input logic mw,
                                         input logic x_load);
    if (mx && !x_load)        return 2'b01;
    else if (mx)              return 2'b00;
    else if (mm)              return 2'b10;
    else if (mw && W_BYPASS)  return 2'b11;
    else                      return 2'b00;
  endfunction

  // Outputs are forced idle while reset is asserted, independent of tag state
  always_comb begin
    stall   = 1'b0;
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (rst_n) begin
      stall   = load_hit && !flush;
      fwd_rs1 = fwd_sel(x1, m1, w1, tag_x_q.is_load);
      fwd_rs2 = fwd_sel(x2, m2, w2, tag_x_q.is_load);
    end
  end

  always_comb begin
    tag_w_d = tag_m_q;
    tag_m_d = tag_x_q;
    tag_x_d = '0;
    // Stalled or killed decode instructions enter execute as a bubble
    if (!stall && !flush) begin
      tag_x_d.valid   = wr_rd;
      tag_x_d.rd      = rd;
      tag_x_d.is_load = is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_x_q <= '0;
      tag_m_q <= '0;
      tag_w_q <= '0;
    end else begin
      tag_x_q <= tag_x_d;
      tag_m_q <= tag_m_d;
      tag_w_q <= tag_w_d;
    end
  end

`ifdef RAW_SCOREBOARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturates at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_raw_scoreboard.sv
module tb_raw_scoreboard;

  localparam logic [31:0] ADDI5  = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADD655 = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] LW5    = 32'h00012283; // lw x5,0(x2)
  localparam logic [31:0] SW5    = 32'h00512023; // sw x5,0(x2)
  localparam logic [31:0] ADDI0  = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD600 = 32'h00000333; // add x6,x0,x0

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_d;
  logic        flush;
  logic        stall, stall_nb;
  logic [1:0]  fwd_rs1, fwd_rs2, fwd_rs1_nb, fwd_rs2_nb;
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_nb;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  raw_scoreboard #(.W_BYPASS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .flush(flush),
    .stall(stall), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  raw_scoreboard #(.W_BYPASS(1'b0), .CNT_W(32)) dut_nb (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .flush(flush),
    .stall(stall_nb), .fwd_rs1(fwd_rs1_nb), .fwd_rs2(fwd_rs2_nb)
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt_nb)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
  endtask

  // Check stall and both forward selects of the main instance
  task automatic chk3(input string tag, input logic s, input logic [1:0] f1, input logic [1:0] f2);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, ".fwd_rs1"}, {30'd0, fwd_rs1}, {30'd0, f1});
    chk({tag, ".fwd_rs2"}, {30'd0, fwd_rs2}, {30'd0, f2});
  endtask

  // Present inst_d for one decode cycle; returns at the negedge for sampling
  task automatic put(input logic [31:0] i, input logic f);
    inst_d = i;
    flush  = f;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) begin
      put(NOP, 1'b0);
      adv();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    inst_d = ADD655;
    flush  = 1'b0;
    @(negedge clk);
    chk3("reset_pre_edge", 1'b0, 2'b00, 2'b00);
    adv();
    put(ADD655, 1'b0);
    chk3("reset_held", 1'b0, 2'b00, 2'b00);
    adv();
    rst_n = 1'b1;

    // Empty pipeline: no hazards
    put(ADDI5, 1'b0);
    chk3("idle", 1'b0, 2'b00, 2'b00);
    adv();
    // Forward from execute
    put(ADD655, 1'b0);
    chk3("fwd_x", 1'b0, 2'b01, 2'b01);
    adv();
    drain();

    // Forward from memory
    put(ADDI5, 1'b0); adv();
    put(NOP, 1'b0);   adv();
    put(ADD655, 1'b0);
    chk3("fwd_m", 1'b0, 2'b10, 2'b10);
    adv();
    drain();

    // Forward from writeback; write-through variant selects regfile
    put(ADDI5, 1'b0); adv();
    put(NOP, 1'b0);   adv();
    put(NOP, 1'b0);   adv();
    put(ADD655, 1'b0);
    chk3("fwd_w", 1'b0, 2'b11, 2'b11);
    chk("fwd_w_nobypass.fwd_rs1", {30'd0, fwd_rs1_nb}, 32'd0);
    chk("fwd_w_nobypass.fwd_rs2", {30'd0, fwd_rs2_nb}, 32'd0);
    adv();
    drain();

    // Three NOPs: result is in the register file
    put(ADDI5, 1'b0); adv();
    drain();
    put(ADD655, 1'b0);
    chk3("fwd_none", 1'b0, 2'b00, 2'b00);
    adv();
    drain();

    // Load-use: one stall, then forward from memory
    put(LW5, 1'b0); adv();
    put(ADD655, 1'b0);
    chk3("lu_stall", 1'b1, 2'b00, 2'b00);
    adv();
    put(ADD655, 1'b0);
    chk3("lu_after", 1'b0, 2'b10, 2'b10);
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
    chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif
    adv();
    drain();

    // Store data operand depends on the load
    put(LW5, 1'b0); adv();
    put(SW5, 1'b0);
    chk3("sw_stall", 1'b1, 2'b00, 2'b00);
    adv();
    put(SW5, 1'b0);
    chk3("sw_after", 1'b0, 2'b00, 2'b10);
    adv();
    drain();

    // x0 never creates a hazard
    put(ADDI0, 1'b0); adv();
    put(ADD600, 1'b0);
    chk3("x0", 1'b0, 2'b00, 2'b00);
    adv();
    drain();

    // Flush overrides the load-use stall and kills the decode tag
    put(LW5, 1'b0); adv();
    put(ADD655, 1'b1);
    chk("flush.stall", {31'd0, stall}, 32'd0);
    adv();
    put(ADD655, 1'b0);
    chk3("flush_after", 1'b0, 2'b10, 2'b10);
    adv();
    drain();

    // Same rd in X, M and W: youngest wins
    put(ADDI5, 1'b0); adv();
    put(ADDI5, 1'b0); adv();
    put(ADDI5, 1'b0); adv();
    put(ADD655, 1'b0);
    chk3("prio_x", 1'b0, 2'b01, 2'b01);
    adv();
    drain();

    // Back-to-back loads: stall only on the nearest, once
    put(LW5, 1'b0); adv();
    put(LW5, 1'b0); adv();
    put(ADD655, 1'b0);
    chk3("ll_stall", 1'b1, 2'b00, 2'b00);
    adv();
    put(ADD655, 1'b0);
    chk3("ll_after", 1'b0, 2'b10, 2'b10);
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
    chk("ll_stall_cnt", stall_cnt, 32'd3);
`endif
    adv();
    drain();

    // Reset mid-stall
    put(LW5, 1'b0); adv();
    put(ADD655, 1'b0);
    chk3("rst_pre", 1'b1, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    chk3("rst_mid", 1'b0, 2'b00, 2'b00);
    adv();
    rst_n = 1'b1;
    put(ADD655, 1'b0);
    chk3("rst_after", 1'b0, 2'b00, 2'b00);
`ifdef RAW_SCOREBOARD_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
